// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Loads a program image from a byte stream, then runs the CPU until
//            halt or cycle-budget expiry.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int               ADDR_W     = 13,
  parameter int               DATA_W     = 8,
  parameter int               CYC_W      = 16,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              cpu_reset,
  input  logic              cpu_mem_rd,
  input  logic              cpu_mem_wr,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_halt,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  remain_q, remain_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CYC_W-1:0]   cycle_q, cycle_d;
  logic               timeout_q, timeout_d;
  logic [CYC_W-1:0]   cycle_inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      remain_q  <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cycle_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cycle_q   <= cycle_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cycle_d   = cycle_q;
    timeout_d = timeout_q;
    cycle_inc = cycle_q + CYC_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cycle_d   = '0;
          timeout_d = 1'b0;
          remain_d  = load_len;
          addr_d    = '0;
          state_d   = (load_len != '0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        // Alternate accept / write cycles; the write cycle retires the byte.
        if (wr_q) begin
          wr_d     = 1'b0;
          wdata_d  = '0;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) begin
            state_d = S_RUN;
          end
        end else if (s_valid) begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data;
        end
      end
      S_RUN: begin
        cycle_d = cycle_inc;
        // Halt takes priority over budget expiry on the same edge.
        if (cpu_halt) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (cycle_inc == MAX_CYCLES) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign s_ready      = (state_q == S_LOAD) && !wr_q;
  assign cpu_reset    = (state_q != S_RUN);
  assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign timeout      = timeout_q;
  assign cycle_count  = cycle_q;

  assign mem_rd       = (state_q == S_RUN) ? cpu_mem_rd  : 1'b0;
  assign mem_wr       = (state_q == S_RUN) ? cpu_mem_wr  : wr_q;
  assign mem_address  = (state_q == S_RUN) ? cpu_address : waddr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wdata_en = (state_q == S_RUN) ? 1'b0 : wr_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Directed and randomized self-checking bench for cpu_run_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int CYC_W  = 16;
  localparam int MAXC   = 10;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] load_len;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              cpu_reset;
  logic              cpu_mem_rd;
  logic              cpu_mem_wr;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_halt;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wdata_en;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CYC_W-1:0]  cycle_count;

  logic [7:0] img [0:15];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cpu_run_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CYC_W      (CYC_W),
    .MAX_CYCLES (16'(MAXC))
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .load_len     (load_len),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .cpu_reset    (cpu_reset),
    .cpu_mem_rd   (cpu_mem_rd),
    .cpu_mem_wr   (cpu_mem_wr),
    .cpu_address  (cpu_address),
    .cpu_halt     (cpu_halt),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_wdata_en (mem_wdata_en),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .cycle_count  (cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Streams img[0..len-1] with random gaps; optionally resets on the write
  // cycle of byte abort_at and checks the idle state that follows.
  task automatic load_image(input int len, input int gap_max, input int abort_at);
    start    = 1'b1;
    load_len = ADDR_W'(len);
    tick();
    start    = 1'b0;
    #1;
    chk("start_clr_count", 32'(cycle_count), 0);
    chk("start_clr_done", 32'(done), 0);
    chk("start_clr_timeout", 32'(timeout), 0);
    for (int i = 0; i < len; i++) begin
      int gaps;
      gaps = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
      for (int g = 0; g < gaps; g++) begin
        s_valid  = 1'b0;
        s_data   = DATA_W'($urandom);
        cpu_halt = 1'($urandom);
        #1;
        chk("gap_ready", 32'(s_ready), 1);
        chk("gap_no_wr", 32'(mem_wr), 0);
        chk("gap_wdata_zero", 32'(mem_wdata), 0);
        chk("gap_no_drive", 32'(mem_wdata_en), 0);
        if (i > 0) chk("gap_addr_hold", 32'(mem_address), i - 1);
        tick();
      end
      s_valid  = 1'b1;
      s_data   = img[i];
      cpu_halt = 1'($urandom);
      #1;
      chk("acc_ready", 32'(s_ready), 1);
      chk("acc_no_wr", 32'(mem_wr), 0);
      chk("acc_cpu_reset", 32'(cpu_reset), 1);
      tick();
      s_valid = 1'($urandom);
      s_data  = DATA_W'($urandom);
      #1;
      chk("wr_strobe", 32'(mem_wr), 1);
      chk("wr_drive", 32'(mem_wdata_en), 1);
      chk("wr_addr", 32'(mem_address), i);
      chk("wr_data", 32'(mem_wdata), 32'(img[i]));
      chk("wr_ready", 32'(s_ready), 0);
      chk("wr_busy", 32'(busy), 1);
      chk("wr_mem_rd", 32'(mem_rd), 0);
      if (i == abort_at) begin
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("abort_no_wr", 32'(mem_wr), 0);
        chk("abort_cpu_reset", 32'(cpu_reset), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_addr", 32'(mem_address), 0);
        chk("abort_ready", 32'(s_ready), 0);
        chk("abort_count", 32'(cycle_count), 0);
        return;
      end
      tick();
    end
    s_valid    = 1'b0;
    cpu_mem_wr = 1'b0;
    cpu_mem_rd = 1'b0;
    #1;
    chk("run_entry_cpu_reset", 32'(cpu_reset), 0);
    chk("run_entry_busy", 32'(busy), 1);
  endtask

  // Expected outcome follows directly from the rules: halt inside the budget
  // ends the run at that cycle, otherwise the budget ends it.
  task automatic run_phase(input int halt_at, input int start_at);
    int exp_end;
    int exp_to;
    exp_to  = (halt_at > 0 && halt_at <= MAXC) ? 0 : 1;
    exp_end = exp_to ? MAXC : halt_at;
    for (int i = 1; i <= exp_end; i++) begin
      cpu_mem_rd  = 1'($urandom);
      cpu_mem_wr  = 1'($urandom);
      cpu_address = ADDR_W'($urandom);
      cpu_halt    = (i == halt_at);
      start       = (i == start_at);
      load_len    = ADDR_W'($urandom_range(5, 1));
      s_valid     = 1'($urandom);
      #1;
      chk("run_cpu_reset", 32'(cpu_reset), 0);
      chk("run_busy", 32'(busy), 1);
      chk("run_mux_rd", 32'(mem_rd), 32'(cpu_mem_rd));
      chk("run_mux_wr", 32'(mem_wr), 32'(cpu_mem_wr));
      chk("run_mux_addr", 32'(mem_address), 32'(cpu_address));
      chk("run_no_drive", 32'(mem_wdata_en), 0);
      chk("run_ready", 32'(s_ready), 0);
      tick();
    end
    cpu_halt   = 1'b0;
    start      = 1'b0;
    cpu_mem_rd = 1'b0;
    cpu_mem_wr = 1'b0;
    s_valid    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      #1;
      chk("done_flag", 32'(done), 1);
      chk("done_timeout", 32'(timeout), exp_to);
      chk("done_count", 32'(cycle_count), exp_end);
      chk("done_cpu_reset", 32'(cpu_reset), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_no_wr", 32'(mem_wr), 0);
      cpu_halt = 1'($urandom);
      tick();
      cpu_halt = 1'b0;
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    load_len    = '0;
    s_valid     = 1'b0;
    s_data      = '0;
    cpu_mem_rd  = 1'b0;
    cpu_mem_wr  = 1'b0;
    cpu_address = '0;
    cpu_halt    = 1'b0;
    repeat (3) tick();

    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_drive", 32'(mem_wdata_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_count", 32'(cycle_count), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Basic three-byte image, halt after five RUN cycles.
    img[0] = 8'hA0; img[1] = 8'h41; img[2] = 8'hE0;
    load_image(3, 0, -1);
    run_phase(5, 0);

    // Zero-length load goes straight to RUN and never offers s_ready.
    s_valid  = 1'b1;
    start    = 1'b1;
    load_len = '0;
    #1;
    chk("len0_ready_pre", 32'(s_ready), 0);
    tick();
    start = 1'b0;
    #1;
    chk("len0_run", 32'(cpu_reset), 0);
    chk("len0_ready", 32'(s_ready), 0);
    chk("len0_no_drive", 32'(mem_wdata_en), 0);
    s_valid = 1'b0;
    run_phase(3, 0);

    // Backpressure with gaps, then budget expiry.
    for (int i = 0; i < 4; i++) img[i] = 8'(8'h10 + i);
    load_image(4, 3, -1);
    run_phase(0, 0);

    // Halt exactly on the last budget cycle wins over timeout.
    load_image(2, 1, -1);
    run_phase(MAXC, 0);

    // Reset on the write cycle of byte 2 of 4, then a full reload from 0.
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    load_image(4, 0, 1);
    load_image(4, 0, -1);
    run_phase(4, 2);

    // Randomized images, gaps, halt points and ignored start pulses.
    for (int t = 0; t < 8; t++) begin
      int len;
      int h;
      len = int'($urandom_range(8, 1));
      for (int i = 0; i < len; i++) img[i] = 8'($urandom);
      load_image(len, 2, -1);
      h = int'($urandom_range(12, 0));
      run_phase(h, int'($urandom_range(9, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the RISC CPU. It loads a program image into the shared 8-bit program/data memory from a byte stream, then holds the CPU in reset until the image is complete. It releases the CPU, counts execution cycles, and detects `halt` or a cycle-budget timeout. It sits between the CPU's memory strobes/address and the memory, and owns the CPU's reset line.

## Interface
- `ADDR_W`, 13, memory address width; matches the CPU `address`.
- `DATA_W`, 8, memory data width.
- `CYC_W`, 16, cycle counter width.
- `MAX_CYCLES`, 16'hFFFF, run-cycle budget before timeout; legal range 1..2^CYC_W-1.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request; honoured only in IDLE or DONE.
- `load_len`  in  ADDR_W  number of bytes to load at addresses 0..load_len-1; sampled with `start`.
- `s_valid`  in  1  load byte valid.
- `s_data`  in  DATA_W  load byte.
- `s_ready`  out  1  controller accepts `s_data` this cycle.
- `cpu_reset`  out  1  drives the CPU `reset`; high in every state except RUN.
- `cpu_mem_rd`, `cpu_mem_wr`  in  1 each  CPU strobes.
- `cpu_address`  in  ADDR_W  CPU address.
- `cpu_halt`  in  1  CPU `halt`.
- `mem_rd`, `mem_wr`  out  1 each  memory strobes.
- `mem_address`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  loader write data.
- `mem_wdata_en`  out  1  loader drives the data bus; the top level tri-states `data_bus` with this.
- `busy`  out  1  state is LOAD or RUN.
- `done`  out  1  state is DONE.
- `timeout`  out  1  DONE was reached by budget expiry, not halt.
- `cycle_count`  out  CYC_W  number of cycles spent in RUN.

## Operation
- States: IDLE, LOAD, RUN, DONE. Encoding is free.
- Reset puts the block in IDLE at the next edge:
  - `cpu_reset`=1.
  - `s_ready`, `mem_rd`, `mem_wr`, `mem_wdata_en`, `busy`, `done`, `timeout` = 0.
  - `mem_address`=0, `mem_wdata`=0, `cycle_count`=0.
- IDLE or DONE with `start`=1:
  - Clear `cycle_count`, `done`, `timeout`. Latch `load_len` into the remaining-byte counter. Load address counter = 0.
  - Next state is LOAD if `load_len`≠0, else RUN.
- LOAD:
  - `s_ready` = 1 when no write is pending.
  - On an accepted byte (`s_valid`&&`s_ready`), register the address and data.
  - The following cycle is the write cycle: `mem_wr`=1, `mem_wdata_en`=1, `mem_address`=load address, `mem_wdata`=byte, `s_ready`=0.
  - After the write cycle, increment the address counter and decrement the remaining counter.
  - When the write of the last byte completes, go to RUN. Sustained throughput is 1 byte per 2 cycles.
  - `s_valid` gaps stall indefinitely; there is no timeout in LOAD.
- Memory mux:
  - In RUN, `mem_rd`/`mem_wr`/`mem_address` follow `cpu_mem_rd`/`cpu_mem_wr`/`cpu_address` combinationally, and `mem_wdata_en`=0.
  - In all other states, the memory outputs are the loader's registered values. Outside write cycles those are 0; `mem_address` holds its last value.
- RUN:
  - `cpu_reset`=0.
  - `cycle_count` increments every RUN cycle, starting at 1 in the first cycle.
  - `cpu_halt`=1 goes to DONE with `timeout`=0.
  - Otherwise, `cycle_count`==`MAX_CYCLES` goes to DONE with `timeout`=1.
  - If halt and budget expiry occur on the same edge, halt wins.
- DONE: `cpu_reset`=1 (CPU frozen). `cycle_count` holds. Remains in DONE until `start` or `reset`.
- `start` is ignored in LOAD and RUN.
- `s_valid` outside LOAD is ignored, and `s_ready`=0.
- `cpu_halt` outside RUN is ignored.

## Timing
- `start` sampled at edge k: LOAD (or RUN if len=0) from k+1; `s_ready`=1 from k+1.
- Byte accepted at edge a: `mem_wr` high for exactly cycle a+1→a+2; next `s_ready` high from a+2.
- Last write cycle ends at edge w: RUN from w, `cpu_reset` low from w.
- `cpu_halt` sampled high at edge h: DONE, `done`=1, `cpu_reset`=1 from h; `cycle_count` equals the RUN cycles up to and including h's cycle.
- `reset` asserted mid-LOAD or mid-RUN: at the next edge, IDLE with all reset values. Any in-flight write pulse is dropped.

## Test plan
- Load `load_len`=3, bytes 8'hA0, 8'h41, 8'hE0, `s_valid` held:
  - `mem_wr` pulses at addr 0, 1, 2 with those data, each 1 cycle, 2 cycles apart.
  - `cpu_reset` falls the cycle after the 3rd write.
  - Halt after 5 RUN cycles → `done`=1, `timeout`=0, `cycle_count`=5, `cpu_reset`=1.
- `load_len`=0 with `start`: RUN next cycle, no `mem_wr` pulse, `s_ready` never high.
- Backpressure: `s_valid` toggling 1,0,0,1 → exactly one write per accepted byte at consecutive addresses, no duplicates.
- `MAX_CYCLES`=10, no halt → DONE after 10 RUN cycles, `timeout`=1, `cycle_count`=10.
- `MAX_CYCLES`=10, halt on RUN cycle 10 → `timeout`=0.
- `reset` pulsed on the write cycle of byte 2 of 4:
  - IDLE next cycle, `mem_wr`=0, `cpu_reset`=1.
  - Subsequent `start` reloads from address 0.
- `start` pulsed during RUN: no effect on state or `cycle_count`.
- `start` from DONE: `done`/`timeout`/`cycle_count` cleared, a new load begins.
